// File: rtl/edge_sum_param.sv
// Pipelined thermometer-code edge encoder: counts tap edges of a selectable
// polarity and sums their global positions, with cascade offset and saturation.
module edge_sum_param #(
   parameter int GROUP  = 6,
   parameter int NGROUP = 8,
   parameter int INDEX  = 0,
   parameter int SUM_W  = 16,
   parameter int CNT_W  = $clog2(GROUP*NGROUP+1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     din_valid,
   input  logic [GROUP*NGROUP-1:0]  din,
   input  logic                     cin,
   input  logic [1:0]               mode,
   output logic                     dout_valid,
   output logic [CNT_W-1:0]         edge_count,
   output logic [SUM_W-1:0]         sum_position,
   output logic                     ovf
);
   localparam int WIDTH = GROUP*NGROUP;
   localparam int LC_W  = $clog2(GROUP+1);
   localparam int LS_W  = $clog2(GROUP*(GROUP+1)/2+1);
   localparam int S_W   = $clog2(WIDTH*(WIDTH+1)/2+1);
   localparam int T_W   = $clog2(WIDTH*(WIDTH+1)/2 + WIDTH*INDEX*WIDTH + 1);
   localparam int X_W   = ((T_W > SUM_W) ? T_W : SUM_W) + 1;
   localparam logic [X_W-1:0] OFFSET = X_W'(INDEX*WIDTH);

   // Valid-only stream: din_valid qualifies din/cin/mode for one cycle; there is
   // no ready, the pipe never stalls, and dout_valid marks each result for one cycle.
   logic [3:0]        vld_d, vld_q;
   logic [WIDTH-1:0]  prev, edge_d, edge_q;
   logic [LC_W-1:0]   gcnt_d [NGROUP];
   logic [LC_W-1:0]   gcnt_q [NGROUP];
   logic [LS_W-1:0]   gsum_d [NGROUP];
   logic [LS_W-1:0]   gsum_q [NGROUP];
   logic [CNT_W-1:0]  ctree [2*NGROUP-1];
   logic [S_W-1:0]    stree [2*NGROUP-1];
   logic [CNT_W-1:0]  cnt3_d, cnt3_q, cnt4_d, cnt4_q;
   logic [S_W-1:0]    sum3_d, sum3_q;
   logic [X_W-1:0]    t_full;
   logic [SUM_W-1:0]  sum4_d, sum4_q;
   logic              ovf4_d, ovf4_q;
   logic              dout_valid_d, dout_valid_q;
   logic [CNT_W-1:0]  edge_count_d, edge_count_q;
   logic [SUM_W-1:0]  sum_position_d, sum_position_q;
   logic              ovf_d, ovf_q;

   // Stage 1: bit i compares against bit i-1, with cin standing in below bit 0.
   always_comb begin
      vld_d = {vld_q[2:0], din_valid};
      prev  = {din[WIDTH-2:0], cin};
      case (mode)
         2'b00:   edge_d = din & ~prev;
         2'b01:   edge_d = ~din & prev;
         default: edge_d = din ^ prev;
      endcase
   end

   // Stage 2: per-group local count and local position sum.
   always_comb begin
      for (int g = 0; g < NGROUP; g++) begin
         gcnt_d[g] = '0;
         gsum_d[g] = '0;
         for (int j = 0; j < GROUP; j++) begin
            if (edge_q[g*GROUP+j]) begin
               gcnt_d[g] = gcnt_d[g] + LC_W'(1);
               gsum_d[g] = gsum_d[g] + LS_W'(j+1);
            end
         end
      end
   end

   // Stage 3: heap-indexed balanced tree, leaves at NGROUP-1 .. 2*NGROUP-2.
   always_comb begin
      for (int g = 0; g < NGROUP; g++) begin
         ctree[NGROUP-1+g] = CNT_W'(gcnt_q[g]);
         stree[NGROUP-1+g] = S_W'(gsum_q[g]) + S_W'(gcnt_q[g]) * S_W'(g*GROUP);
      end
      for (int k = NGROUP-2; k >= 0; k--) begin
         ctree[k] = ctree[2*k+1] + ctree[2*k+2];
         stree[k] = stree[2*k+1] + stree[2*k+2];
      end
      cnt3_d = ctree[0];
      sum3_d = stree[0];
   end

   // Stage 4 and output registers; X_W always leaves at least one bit above SUM_W.
   always_comb begin
      t_full         = X_W'(sum3_q) + X_W'(cnt3_q) * OFFSET;
      ovf4_d         = |t_full[X_W-1:SUM_W];
      sum4_d         = ovf4_d ? '1 : t_full[SUM_W-1:0];
      cnt4_d         = cnt3_q;
      dout_valid_d   = vld_q[3];
      edge_count_d   = vld_q[3] ? cnt4_q : edge_count_q;
      sum_position_d = vld_q[3] ? sum4_q : sum_position_q;
      ovf_d          = vld_q[3] ? ovf4_q : ovf_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q          <= '0;
         edge_q         <= '0;
         for (int g = 0; g < NGROUP; g++) begin
            gcnt_q[g] <= '0;
            gsum_q[g] <= '0;
         end
         cnt3_q         <= '0;
         sum3_q         <= '0;
         cnt4_q         <= '0;
         sum4_q         <= '0;
         ovf4_q         <= 1'b0;
         dout_valid_q   <= 1'b0;
         edge_count_q   <= '0;
         sum_position_q <= '0;
         ovf_q          <= 1'b0;
      end else begin
         vld_q          <= vld_d;
         edge_q         <= edge_d;
         for (int g = 0; g < NGROUP; g++) begin
            gcnt_q[g] <= gcnt_d[g];
            gsum_q[g] <= gsum_d[g];
         end
         cnt3_q         <= cnt3_d;
         sum3_q         <= sum3_d;
         cnt4_q         <= cnt4_d;
         sum4_q         <= sum4_d;
         ovf4_q         <= ovf4_d;
         dout_valid_q   <= dout_valid_d;
         edge_count_q   <= edge_count_d;
         sum_position_q <= sum_position_d;
         ovf_q          <= ovf_d;
      end
   end

   assign dout_valid   = dout_valid_q;
   assign edge_count   = edge_count_q;
   assign sum_position = sum_position_q;
   assign ovf          = ovf_q;

endmodule

// File: tb/tb_edge_sum_param.sv
// Bench for edge_sum_param: four parameterisations driven in lockstep, checked
// every cycle against a positional edge model with timestamped expectations.
module tb_edge_sum_param;

   typedef struct packed {
      logic [31:0] due;
      logic [7:0]  cnt;
      logic [31:0] sum;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        din_valid;
   logic [47:0] din48;
   logic [15:0] din16;
   logic        cin;
   logic [1:0]  mode;

   logic        dv0, dv1, dv2, dv3;
   logic [5:0]  cnt0, cnt1, cnt2;
   logic [4:0]  cnt3;
   logic [15:0] sum0, sum1, sum3;
   logic [11:0] sum2;
   logic        ovf0, ovf1, ovf2, ovf3;

   logic        a_dv  [4];
   logic [7:0]  a_cnt [4];
   logic [31:0] a_sum [4];
   logic        a_ovf [4];

   exp_t exp_q [4][$];
   exp_t last [4];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   edge_sum_param u0 (
      .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din48), .cin(cin), .mode(mode),
      .dout_valid(dv0), .edge_count(cnt0), .sum_position(sum0), .ovf(ovf0));
   edge_sum_param #(.INDEX(2)) u1 (
      .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din48), .cin(cin), .mode(mode),
      .dout_valid(dv1), .edge_count(cnt1), .sum_position(sum1), .ovf(ovf1));
   edge_sum_param #(.INDEX(2), .SUM_W(12)) u2 (
      .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din48), .cin(cin), .mode(mode),
      .dout_valid(dv2), .edge_count(cnt2), .sum_position(sum2), .ovf(ovf2));
   edge_sum_param #(.GROUP(4), .NGROUP(4), .INDEX(1)) u3 (
      .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din16), .cin(cin), .mode(mode),
      .dout_valid(dv3), .edge_count(cnt3), .sum_position(sum3), .ovf(ovf3));

   assign a_dv[0] = dv0;  assign a_cnt[0] = 8'(cnt0);  assign a_sum[0] = 32'(sum0);  assign a_ovf[0] = ovf0;
   assign a_dv[1] = dv1;  assign a_cnt[1] = 8'(cnt1);  assign a_sum[1] = 32'(sum1);  assign a_ovf[1] = ovf1;
   assign a_dv[2] = dv2;  assign a_cnt[2] = 8'(cnt2);  assign a_sum[2] = 32'(sum2);  assign a_ovf[2] = ovf2;
   assign a_dv[3] = dv3;  assign a_cnt[3] = 8'(cnt3);  assign a_sum[3] = 32'(sum3);  assign a_ovf[3] = ovf3;

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Walk the taps, collect each qualifying edge's global position, then saturate.
   function automatic exp_t model(input logic [47:0] d, input int w, input logic c,
                                  input logic [1:0] m, input int idx, input int sw);
      exp_t   r;
      longint t, lim;
      int     n;
      logic   pv, cur, hit;
      t = 0; n = 0; pv = c;
      for (int i = 0; i < w; i++) begin
         cur = d[i];
         case (m)
            2'b00:   hit = cur && !pv;
            2'b01:   hit = !cur && pv;
            default: hit = cur != pv;
         endcase
         if (hit) begin
            n++;
            t += longint'(i + 1 + idx*w);
         end
         pv = cur;
      end
      lim   = (longint'(1) << sw) - 1;
      r.due = '0;
      r.cnt = 8'(n);
      r.ovf = (t > lim);
      r.sum = 32'((t > lim) ? lim : t);
      return r;
   endfunction

   // driver: inputs change on the falling edge, capture happens on the next rising edge
   task automatic drive(input logic v, input logic [47:0] d, input logic [15:0] d16,
                        input logic c, input logic [1:0] m);
      exp_t e [4];
      @(negedge clk);
      din_valid = v; din48 = d; din16 = d16; cin = c; mode = m;
      if (v) begin
         e[0] = model(d, 48, c, m, 0, 16);
         e[1] = model(d, 48, c, m, 2, 16);
         e[2] = model(d, 48, c, m, 2, 12);
         e[3] = model(48'(d16), 16, c, m, 1, 16);
         for (int k = 0; k < 4; k++) begin
            e[k].due = 32'(cyc + 5);
            exp_q[k].push_back(e[k]);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 48'h0, 16'h0, 1'b0, 2'b00);
   endtask

   // Pins the model to hand-computed results, then applies the vector.
   task automatic drive_chk(input logic [47:0] d, input logic c, input logic [1:0] m,
                            input int c0, input int s0, input int s2, input int s2s, input logic o2s);
      exp_t r0, r1, r2;
      r0 = model(d, 48, c, m, 0, 16);
      r1 = model(d, 48, c, m, 2, 16);
      r2 = model(d, 48, c, m, 2, 12);
      n_vec++;
      if (r0.cnt != 8'(c0) || r0.sum != 32'(s0) || r0.ovf || r1.cnt != 8'(c0) ||
          r1.sum != 32'(s2) || r1.ovf || r2.sum != 32'(s2s) || r2.ovf != o2s) begin
         n_err++;
         $display("FAIL pin d=%h m=%b c=%b: got cnt=%0d sum=%0d/%0d/%0d ovf=%0d, want cnt=%0d sum=%0d/%0d/%0d ovf=%0d",
                  d, m, c, r0.cnt, r0.sum, r1.sum, r2.sum, r2.ovf, c0, s0, s2, s2s, o2s);
      end
      drive(1'b1, d, d[15:0], c, m);
   endtask

   // scoreboard: every falling edge, each DUT shows either its due result or held values
   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         exp_t w;
         logic wv;
         wv = 1'b0;
         if (rst_n && exp_q[k].size() > 0 && exp_q[k][0].due == 32'(cyc)) begin
            w = exp_q[k].pop_front();
            last[k] = w;
            wv = 1'b1;
         end else begin
            w = last[k];
         end
         n_vec++;
         if (a_dv[k] !== wv || a_cnt[k] !== w.cnt || a_sum[k] !== w.sum || a_ovf[k] !== w.ovf) begin
            n_err++;
            $display("FAIL out dut%0d cyc%0d: got v=%0d cnt=%0d sum=%0d ovf=%0d, want v=%0d cnt=%0d sum=%0d ovf=%0d",
                     k, cyc, a_dv[k], a_cnt[k], a_sum[k], a_ovf[k], wv, w.cnt, w.sum, w.ovf);
         end
      end
   end

   initial begin
      for (int k = 0; k < 4; k++) last[k] = '0;
      rst_n = 1'b0; din_valid = 1'b0; din48 = '0; din16 = '0; cin = 1'b0; mode = 2'b00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle(1);

      // polarity on a single step
      drive_chk(48'h0000_0000_FFFF, 1'b0, 2'b10, 2, 18, 210, 210, 1'b0);
      drive_chk(48'h0000_0000_FFFF, 1'b0, 2'b00, 1, 1, 97, 97, 1'b0);
      drive_chk(48'h0000_0000_FFFF, 1'b0, 2'b01, 1, 17, 113, 113, 1'b0);
      idle(3);

      // streaming: three back-to-back, 2-cycle gap, one more
      drive_chk(48'hC000_0000_0000, 1'b0, 2'b00, 1, 47, 143, 143, 1'b0);
      drive_chk(48'h0000_0000_0000, 1'b1, 2'b01, 1, 1, 97, 97, 1'b0);
      drive_chk(48'h5555_5555_5555, 1'b0, 2'b10, 48, 1176, 5784, 4095, 1'b1);
      idle(2);
      drive_chk(48'h5555_5555_5555, 1'b0, 2'b00, 24, 576, 2880, 2880, 1'b0);
      idle(2);

      // boundaries: no edges, top tap, mode 11
      drive_chk(48'hFFFF_FFFF_FFFF, 1'b1, 2'b10, 0, 0, 0, 0, 1'b0);
      drive_chk(48'h8000_0000_0000, 1'b0, 2'b10, 1, 48, 144, 144, 1'b0);
      drive_chk(48'h0000_0000_0000, 1'b0, 2'b11, 0, 0, 0, 0, 1'b0);
      drive_chk(48'hFFFF_FFFF_FFFF, 1'b0, 2'b11, 1, 1, 97, 97, 1'b0);
      idle(6);

      // reset while two samples sit in stages 2 and 3
      drive_chk(48'h5555_5555_5555, 1'b0, 2'b10, 48, 1176, 5784, 4095, 1'b1);
      drive_chk(48'h0000_0000_FFFF, 1'b0, 2'b10, 2, 18, 210, 210, 1'b0);
      idle(1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         n_vec++;
         if (a_dv[k] !== 1'b0 || a_cnt[k] !== 8'd0 || a_sum[k] !== 32'd0 || a_ovf[k] !== 1'b0) begin
            n_err++;
            $display("FAIL rst dut%0d: got v=%0d cnt=%0d sum=%0d ovf=%0d, want all 0",
                     k, a_dv[k], a_cnt[k], a_sum[k], a_ovf[k]);
         end
         exp_q[k].delete();
         last[k] = '0;
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      drive_chk(48'h0000_0000_FFFF, 1'b0, 2'b10, 2, 18, 210, 210, 1'b0);
      idle(7);

      // mixed traffic, also exercising the 16-tap INDEX=1 instance
      for (int i = 0; i < 200; i++) begin
         drive($urandom_range(0, 3) != 0, {16'($urandom), 32'($urandom)}, 16'($urandom),
               1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      end
      idle(1);

      for (int i = 0; i < 20; i++) begin
         if (exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
             exp_q[2].size() == 0 && exp_q[3].size() == 0) break;
         @(negedge clk);
      end
      for (int k = 0; k < 4; k++) begin
         n_vec++;
         if (exp_q[k].size() != 0) begin
            n_err++;
            $display("FAIL drain dut%0d: got %0d pending results, want 0", k, exp_q[k].size());
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/edge_sum_param.md
# edge_sum_param

Parametrised, fully pipelined thermometer-code edge encoder for the TDC delay-line readout. It splits a `WIDTH = GROUP*NGROUP`-bit tap snapshot into groups and detects edges with selectable polarity. It outputs the edge count and the sum of global edge positions, offset by block `INDEX` for cascading. A valid strobe travels with the data, and the sum saturates with an overflow flag.

## Interface
- `GROUP`, 6, taps per group (≥2)
- `NGROUP`, 8, number of groups (≥2, power of 2); `WIDTH = GROUP*NGROUP`
- `INDEX`, 0, cascade block index; every position is offset by `INDEX*WIDTH`
- `SUM_W`, 16, width of `sum_position`
- `CNT_W`, `$clog2(WIDTH+1)` (derived), width of `edge_count`
- Reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: clock, all logic on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `din_valid` in 1: `din`/`cin`/`mode` are valid this cycle.
- `din` in WIDTH: tap snapshot; bit i is position i+1.
- `cin` in 1: MSB tap of the previous cascaded block; used as `din[-1]`. Tie to 0 for block 0.
- `mode` in 2: 00 rising, 01 falling, 10/11 both.
- `dout_valid` out 1: one-cycle strobe per accepted sample.
- `edge_count` out CNT_W: number of edges.
- `sum_position` out SUM_W: sum of (p + INDEX*WIDTH) over all edges, saturated.
- `ovf` out 1: set when the true sum exceeds 2^SUM_W−1.

## Operation
- Edge definition at bit i (0..WIDTH−1), with prev = `din[i-1]` and prev = `cin` when i=0:
  - Rising: din[i]=1 and prev=0.
  - Falling: din[i]=0 and prev=1.
  - Both: din[i]≠prev.
- An edge at bit i has position p=i+1.
- Stage 1: register the edge vector, `mode`-qualified, together with `din_valid`.
- Stage 2: per group g, compute local count c_g (0..GROUP) and local sum s_g (Σ local positions 1..GROUP). Register them.
- Stage 3: compute C=Σc_g and S=Σ(s_g + c_g*g*GROUP) with a balanced adder tree. Register them.
- Stage 4:
  - Compute T = S + C*INDEX*WIDTH at full internal width (no truncation).
  - If T > 2^SUM_W−1, set `sum_position` = all ones and `ovf`=1; otherwise `sum_position`=T and `ovf`=0.
  - Set `edge_count`=C.
- Output update rule:
  - Output registers load only when the stage-4 valid bit is 1, and hold otherwise.
  - `dout_valid` equals the stage-4 valid bit.
- Samples with `din_valid`=0 never produce a `dout_valid` pulse. Their data may propagate internally but never reaches the outputs.
- `mode` and `cin` are sampled together with `din`; changing them between samples affects only the next sample.
- Reset (asynchronous assert, any time): all pipeline valid bits clear, `dout_valid`/`edge_count`/`sum_position`/`ovf` = 0, and in-flight samples are discarded.
- Deassertion is synchronised externally. The first valid sample after release is accepted normally.

## Timing
- Latency is exactly 4 cycles: a sample accepted at edge N appears with `dout_valid`=1 after edge N+4.
- Throughput is one sample per cycle, with no backpressure and no stalls.
- Back-to-back valids produce back-to-back `dout_valid`, in order.
- Gaps in `din_valid` reproduce the same gaps at the output, shifted by 4 cycles.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Default parameters, `mode`=10, `cin`=0, `din`=48'h0000_0000_FFFF:
  - Edges at p=1 and p=17, so `edge_count`=2, `sum_position`=18, `ovf`=0, 4 cycles after input.
  - With `mode`=00: count 1, sum 1. With `mode`=01: count 1, sum 17.
- Cascade offset, `INDEX`=2, `mode`=00, `cin`=0, `din`=48'hC000_0000_0000:
  - Expect count 1, sum 47+96=143.
  - With `cin`=1, `din`=0, `mode`=01: count 1, sum 1+96=97.
- Full toggle, `din`=48'h5555_5555_5555, `mode`=10, `cin`=0:
  - `INDEX`=0 gives count 48, sum 1176.
  - `INDEX`=2 gives sum 5784.
  - `INDEX`=2 with `SUM_W`=12 gives sum 4095, `ovf`=1.
- Streaming: three consecutive valid words (the three above), then 2 idle cycles, then one more word.
  - Expect three consecutive `dout_valid` pulses with matching results, then a 2-cycle gap with outputs held, then the fourth result.
- Reset mid-flight: assert `rst_n`=0 while 2 samples are in stages 2–3.
  - All outputs go to 0 immediately and no `dout_valid` appears for those samples.
  - A new sample after release returns correctly after 4 cycles.
- Parameter sweep: `GROUP`=4, `NGROUP`=4, `INDEX`=1, random `din`/`mode`/`cin`.
  - Compare every output against a reference model.
